// File: rtl/prog_mem.sv
// Loadable program memory: the CPU reads combinationally; a streaming loader rewrites the whole image.
// Optional parity checking of load words is enabled by defining PROG_MEM_PARITY_EN.
module prog_mem #(
  parameter int                 ADDR_W   = 4,
  parameter int                 DATA_W   = 8,
  parameter logic [DATA_W-1:0]  NOP_WORD = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count
`ifdef PROG_MEM_PARITY_EN
  ,
  input  logic              ld_par,
  output logic              ld_err
`endif
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   ptr_r;
  logic [ADDR_W:0]     count_r;
  logic                ready_r;
  logic                busy_r;
  logic                done_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic                wr_en_s;
  logic                start_ok_s;

  assign ld_ready = ready_r;
  assign ld_busy  = busy_r;
  assign ld_done  = done_r;
  assign ld_count = count_r;

  // Transfer and restart qualifiers derived from the current state.
  always_comb begin
    wr_en_s    = 1'b0;
    start_ok_s = 1'b0;
    if (state_r == LOAD) begin
      wr_en_s = ld_valid;
    end else if (state_r == IDLE) begin
      start_ok_s = ld_start;
    end else begin
      wr_en_s    = 1'b0;
      start_ok_s = 1'b0;
    end
  end

  // Fetch path: zero-latency read, replaced by NOP while the image is being rewritten.
  always_comb begin
    data = mem_r[address];
    if (state_r == LOAD) begin
      data = NOP_WORD;
    end else begin
      data = mem_r[address];
    end
  end

  // Loader FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= {ADDR_W{1'b0}};
      count_r <= {(ADDR_W + 1){1'b0}};
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (ld_start) begin
            state_r <= LOAD;
            ptr_r   <= {ADDR_W{1'b0}};
            count_r <= {(ADDR_W + 1){1'b0}};
            ready_r <= 1'b1;
            busy_r  <= 1'b1;
          end
        end
        LOAD: begin
          if (ld_valid) begin
            ptr_r   <= ptr_r + PTR_ONE;
            count_r <= count_r + CNT_ONE;
            if (ptr_r == PTR_LAST) begin
              state_r <= DONE;
              ready_r <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Instruction storage; reset leaves an all-zero image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_r[ptr_r] <= ld_data;
    end
  end

`ifdef PROG_MEM_PARITY_EN
  function automatic logic parity_f(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction

  logic err_r;
  assign ld_err = err_r;

  // Sticky parity error; a bad word is still written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (start_ok_s) begin
      err_r <= 1'b0;
    end else if (wr_en_s && (parity_f(ld_data) != ld_par)) begin
      err_r <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_prog_mem.sv
// Randomized bench for prog_mem, checked every cycle against a transaction-level model.
module tb_prog_mem;

  localparam logic [7:0] NOP = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] address;
  logic [7:0] data;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       ld_busy;
  logic       ld_done;
  logic [4:0] ld_count;
`ifdef PROG_MEM_PARITY_EN
  logic       ld_par;
  logic       ld_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: image contents plus load progress.
  logic [7:0] m_mem [16];
  bit         m_loading;
  bit         m_done;
  int         m_count;
  bit         m_err;

  prog_mem dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .address  (address),
    .data     (data),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_busy  (ld_busy),
    .ld_done  (ld_done),
    .ld_count (ld_count)
`ifdef PROG_MEM_PARITY_EN
    ,
    .ld_par   (ld_par),
    .ld_err   (ld_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_loading = 1'b0;
    m_done    = 1'b0;
    m_count   = 0;
    m_err     = 1'b0;
  endtask

  // One clock cycle: drive, check outputs against the model, then advance the model.
  task automatic step(input logic st, input logic vl, input logic [7:0] wd,
                      input logic bad, input logic [3:0] addr);
    @(negedge clk);
    ld_start = st;
    ld_valid = vl;
    ld_data  = wd;
    address  = addr;
`ifdef PROG_MEM_PARITY_EN
    ld_par   = (^wd) ^ bad;
`endif
    #1;
    check("busy",  {31'd0, ld_busy},  {31'd0, m_loading});
    check("ready", {31'd0, ld_ready}, {31'd0, m_loading});
    check("done",  {31'd0, ld_done},  {31'd0, m_done});
    check("count", {27'd0, ld_count}, m_count);
    check("data",  {24'd0, data},     {24'd0, (m_loading ? NOP : m_mem[addr])});
`ifdef PROG_MEM_PARITY_EN
    check("err",   {31'd0, ld_err},   {31'd0, m_err});
`endif
    @(posedge clk);
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_loading) begin
      if (vl) begin
        m_mem[m_count] = wd;
        if (bad) m_err = 1'b1;
        m_count++;
        if (m_count == 16) begin
          m_loading = 1'b0;
          m_done    = 1'b1;
        end
      end
    end else if (st) begin
      m_loading = 1'b1;
      m_count   = 0;
      m_err     = 1'b0;
    end
  endtask

  task automatic sweep(input bit poke_valid);
    for (int a = 0; a < 16; a++) begin
      step(1'b0, poke_valid & 1'(a % 2), 8'($urandom_range(255, 0)), 1'b0, 4'(a));
    end
  endtask

  function automatic logic [3:0] raddr();
    return 4'($urandom_range(15, 0));
  endfunction

  function automatic logic [7:0] rword();
    return 8'($urandom_range(255, 0));
  endfunction

  logic [7:0] words [16];

  initial begin
    rst_n    = 1'b0;
    address  = 4'h0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_data  = 8'h00;
`ifdef PROG_MEM_PARITY_EN
    ld_par   = 1'b0;
`endif
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset image, then valid pulses in IDLE must not write.
    sweep(1'b0);
    sweep(1'b1);

    // Full back-to-back load.
    words[0] = 8'hB7;
    words[1] = 8'h01;
    words[2] = 8'hE1;
    for (int i = 3; i < 16; i++) words[i] = rword();
    step(1'b1, 1'b0, 8'h00, 1'b0, raddr());
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, words[i], 1'b0, raddr());
    step(1'b0, 1'b1, rword(), 1'b0, raddr());
    step(1'b0, 1'b0, 8'h00, 1'b0, raddr());
    sweep(1'b0);
    for (int i = 0; i < 16; i++) check("image", {24'd0, m_mem[i]}, {24'd0, words[i]});

    // Throttled load: valid alternates every cycle.
    step(1'b1, 1'b0, 8'h00, 1'b0, raddr());
    for (int c = 0; c < 32; c++) step(1'b0, (c % 2) == 0, rword(), 1'b0, raddr());
    step(1'b0, 1'b0, 8'h00, 1'b0, raddr());
    sweep(1'b1);

    // Reset in the middle of a load.
    step(1'b1, 1'b0, 8'h00, 1'b0, raddr());
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, rword(), 1'b0, raddr());
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_busy",  {31'd0, ld_busy},  32'd0);
    check("rst_ready", {31'd0, ld_ready}, 32'd0);
    check("rst_done",  {31'd0, ld_done},  32'd0);
    check("rst_count", {27'd0, ld_count}, 32'd0);
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      check("rst_data", {24'd0, data}, 32'd0);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    sweep(1'b1);

    // ld_start during a load is ignored; valid in IDLE/DONE is ignored.
    step(1'b1, 1'b0, 8'h00, 1'b0, raddr());
    for (int i = 0; i < 16; i++) step(i == 7, 1'b1, rword(), 1'b0, raddr());
    step(1'b1, 1'b1, rword(), 1'b0, raddr());
    sweep(1'b1);

    // Randomly gapped load with random start noise.
    step(1'b1, 1'b0, 8'h00, 1'b0, raddr());
    for (int c = 0; c < 60; c++) step($urandom_range(1, 0) == 1, $urandom_range(2, 0) != 0, rword(), 1'b0, raddr());
    sweep(1'b0);

`ifdef PROG_MEM_PARITY_EN
    // Bad parity on word 3 sticks past ld_done until the next start.
    step(1'b1, 1'b0, 8'h00, 1'b0, raddr());
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, rword(), i == 3, raddr());
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rword(), 1'b1, raddr());
    step(1'b1, 1'b0, 8'h00, 1'b0, raddr());
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, rword(), 1'b0, raddr());
    sweep(1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
